// File: rtl/qpu_dtcm_icb_arbiter_pkg.sv
// Shared constants for the DTCM ICB arbiter: port-id encodings and default sizes.
package qpu_dtcm_icb_arbiter_pkg;

  localparam logic PORT_LSU  = 1'b0;
  localparam logic PORT_MEAS = 1'b1;

  localparam int DEF_AW   = 16;
  localparam int DEF_DW   = 32;
  localparam int DEF_OUTS = 2;

  // Pointer width that stays legal for a depth-1 FIFO.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/qpu_dtcm_icb_arbiter_fifo.sv
// Route FIFO holding the granted port id of each outstanding DTCM command.
// Full blocks a push even when a pop happens in the same cycle.
module qpu_dtcm_icb_arbiter_fifo
  import qpu_dtcm_icb_arbiter_pkg::*;
#(
  parameter int DP = 2,
  parameter int DW = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic [DW-1:0] head
);

  localparam int PW = ptr_width(DP);
  localparam int CW = $clog2(DP + 1);

  logic [DW-1:0] mem [DP];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == CW'(DP));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/qpu_dtcm_icb_arbiter.sv
// Two-requester ICB arbiter (LSU = port 0, measurement writer = port 1) onto one DTCM port.
// Round-robin command grant, locked while stalled; responses routed in order via a route FIFO.
module qpu_dtcm_icb_arbiter
  import qpu_dtcm_icb_arbiter_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int DW   = DEF_DW,
  parameter int OUTS = DEF_OUTS
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            lsu_icb_cmd_valid,
  output logic            lsu_icb_cmd_ready,
  input  logic [AW-1:0]   lsu_icb_cmd_addr,
  input  logic            lsu_icb_cmd_read,
  input  logic [DW-1:0]   lsu_icb_cmd_wdata,
  input  logic [DW/8-1:0] lsu_icb_cmd_wmask,
  output logic            lsu_icb_rsp_valid,
  input  logic            lsu_icb_rsp_ready,
  output logic [DW-1:0]   lsu_icb_rsp_rdata,

  input  logic            meas_icb_cmd_valid,
  output logic            meas_icb_cmd_ready,
  input  logic [AW-1:0]   meas_icb_cmd_addr,
  input  logic            meas_icb_cmd_read,
  input  logic [DW-1:0]   meas_icb_cmd_wdata,
  input  logic [DW/8-1:0] meas_icb_cmd_wmask,
  output logic            meas_icb_rsp_valid,
  input  logic            meas_icb_rsp_ready,
  output logic [DW-1:0]   meas_icb_rsp_rdata,

  output logic            dtcm_icb_cmd_valid,
  input  logic            dtcm_icb_cmd_ready,
  output logic [AW-1:0]   dtcm_icb_cmd_addr,
  output logic            dtcm_icb_cmd_read,
  output logic [DW-1:0]   dtcm_icb_cmd_wdata,
  output logic [DW/8-1:0] dtcm_icb_cmd_wmask,
  input  logic            dtcm_icb_rsp_valid,
  output logic            dtcm_icb_rsp_ready,
  input  logic [DW-1:0]   dtcm_icb_rsp_rdata,

  output logic            arb_active
);

  logic gnt;
  logic gnt_valid;
  logic last_gnt;
  logic lock;
  logic lock_id;
  logic fifo_full;
  logic fifo_empty;
  logic head;
  logic cmd_hsk;
  logic rsp_hsk;

  always_comb begin
    gnt = PORT_LSU;
    if (lock)                                       gnt = lock_id;
    else if (lsu_icb_cmd_valid & meas_icb_cmd_valid) gnt = ~last_gnt;
    else if (meas_icb_cmd_valid)                     gnt = PORT_MEAS;
  end

  assign gnt_valid          = (gnt == PORT_MEAS) ? meas_icb_cmd_valid : lsu_icb_cmd_valid;
  assign dtcm_icb_cmd_valid = gnt_valid & ~fifo_full;
  assign dtcm_icb_cmd_addr  = (gnt == PORT_MEAS) ? meas_icb_cmd_addr  : lsu_icb_cmd_addr;
  assign dtcm_icb_cmd_read  = (gnt == PORT_MEAS) ? meas_icb_cmd_read  : lsu_icb_cmd_read;
  assign dtcm_icb_cmd_wdata = (gnt == PORT_MEAS) ? meas_icb_cmd_wdata : lsu_icb_cmd_wdata;
  assign dtcm_icb_cmd_wmask = (gnt == PORT_MEAS) ? meas_icb_cmd_wmask : lsu_icb_cmd_wmask;

  assign lsu_icb_cmd_ready  = (gnt == PORT_LSU)  & dtcm_icb_cmd_ready & ~fifo_full;
  assign meas_icb_cmd_ready = (gnt == PORT_MEAS) & dtcm_icb_cmd_ready & ~fifo_full;
  assign cmd_hsk            = dtcm_icb_cmd_valid & dtcm_icb_cmd_ready;

  // A response with no outstanding command is a DTCM fault: never acked, never forwarded.
  assign lsu_icb_rsp_valid  = dtcm_icb_rsp_valid & ~fifo_empty & (head == PORT_LSU);
  assign meas_icb_rsp_valid = dtcm_icb_rsp_valid & ~fifo_empty & (head == PORT_MEAS);
  assign lsu_icb_rsp_rdata  = dtcm_icb_rsp_rdata;
  assign meas_icb_rsp_rdata = dtcm_icb_rsp_rdata;
  assign dtcm_icb_rsp_ready = ~fifo_empty &
                              ((head == PORT_MEAS) ? meas_icb_rsp_ready : lsu_icb_rsp_ready);
  assign rsp_hsk            = dtcm_icb_rsp_valid & dtcm_icb_rsp_ready;

  assign arb_active = lsu_icb_cmd_valid | meas_icb_cmd_valid | ~fifo_empty;

  // Lock keeps dtcm_icb_cmd_valid stable if the other port asserts mid-stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt <= PORT_MEAS;
      lock     <= 1'b0;
      lock_id  <= PORT_LSU;
    end else if (cmd_hsk) begin
      last_gnt <= gnt;
      lock     <= 1'b0;
    end else if (dtcm_icb_cmd_valid) begin
      lock     <= 1'b1;
      lock_id  <= gnt;
    end
  end

  qpu_dtcm_icb_arbiter_fifo #(
    .DP (OUTS),
    .DW (1)
  ) u_route_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_hsk),
    .push_data (gnt),
    .pop       (rsp_hsk),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

endmodule

// File: tb/tb_qpu_dtcm_icb_arbiter.sv
// Directed bench for qpu_dtcm_icb_arbiter: per-cycle compare against a queue-based model
// plus literal grant/response sequences for each scenario.
module tb_qpu_dtcm_icb_arbiter;

  localparam int AW   = 16;
  localparam int DW   = 32;
  localparam int MW   = DW / 8;
  localparam int OUTS = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lsu_icb_cmd_valid, lsu_icb_cmd_ready, lsu_icb_cmd_read;
  logic [AW-1:0] lsu_icb_cmd_addr;
  logic [DW-1:0] lsu_icb_cmd_wdata, lsu_icb_rsp_rdata;
  logic [MW-1:0] lsu_icb_cmd_wmask;
  logic          lsu_icb_rsp_valid, lsu_icb_rsp_ready;
  logic          meas_icb_cmd_valid, meas_icb_cmd_ready, meas_icb_cmd_read;
  logic [AW-1:0] meas_icb_cmd_addr;
  logic [DW-1:0] meas_icb_cmd_wdata, meas_icb_rsp_rdata;
  logic [MW-1:0] meas_icb_cmd_wmask;
  logic          meas_icb_rsp_valid, meas_icb_rsp_ready;
  logic          dtcm_icb_cmd_valid, dtcm_icb_cmd_ready, dtcm_icb_cmd_read;
  logic [AW-1:0] dtcm_icb_cmd_addr;
  logic [DW-1:0] dtcm_icb_cmd_wdata, dtcm_icb_rsp_rdata;
  logic [MW-1:0] dtcm_icb_cmd_wmask;
  logic          dtcm_icb_rsp_valid, dtcm_icb_rsp_ready;
  logic          arb_active;

  qpu_dtcm_icb_arbiter #(.AW(AW), .DW(DW), .OUTS(OUTS)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
    .lsu_icb_rsp_valid(lsu_icb_rsp_valid), .lsu_icb_rsp_ready(lsu_icb_rsp_ready),
    .lsu_icb_rsp_rdata(lsu_icb_rsp_rdata),
    .meas_icb_cmd_valid(meas_icb_cmd_valid), .meas_icb_cmd_ready(meas_icb_cmd_ready),
    .meas_icb_cmd_addr(meas_icb_cmd_addr), .meas_icb_cmd_read(meas_icb_cmd_read),
    .meas_icb_cmd_wdata(meas_icb_cmd_wdata), .meas_icb_cmd_wmask(meas_icb_cmd_wmask),
    .meas_icb_rsp_valid(meas_icb_rsp_valid), .meas_icb_rsp_ready(meas_icb_rsp_ready),
    .meas_icb_rsp_rdata(meas_icb_rsp_rdata),
    .dtcm_icb_cmd_valid(dtcm_icb_cmd_valid), .dtcm_icb_cmd_ready(dtcm_icb_cmd_ready),
    .dtcm_icb_cmd_addr(dtcm_icb_cmd_addr), .dtcm_icb_cmd_read(dtcm_icb_cmd_read),
    .dtcm_icb_cmd_wdata(dtcm_icb_cmd_wdata), .dtcm_icb_cmd_wmask(dtcm_icb_cmd_wmask),
    .dtcm_icb_rsp_valid(dtcm_icb_rsp_valid), .dtcm_icb_rsp_ready(dtcm_icb_rsp_ready),
    .dtcm_icb_rsp_rdata(dtcm_icb_rsp_rdata),
    .arb_active(arb_active)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Stimulus state: remaining commands per requester and DTCM pending responses.
  int            lcnt = 0, mcnt = 0;
  logic [AW-1:0] laddr = '0, maddr = '0;
  logic          cmd_rdy = 1'b1, rsp_en = 1'b1;
  logic [AW-1:0] pend[$];

  // Events observed at the last falling edge.
  bit            l_hsk_q, m_hsk_q, c_hsk_q, r_hsk_q;
  logic [AW-1:0] c_addr_q;
  int            gnt_log[$];
  int            rsp_port[$];
  logic [DW-1:0] rsp_data[$];

  // Model: outstanding port ids in order, last accepted port, port held by a stall (-1 none).
  int mq[$];
  int m_last = 1, m_stall = -1, m_win = 0, m_nstall = -1;
  bit m_acc = 0, m_pop = 0;

  always @(negedge clk) begin
    int win, head;
    bit lv, mv, wv, full, empty, edv, edrr;
    lv    = lsu_icb_cmd_valid;
    mv    = meas_icb_cmd_valid;
    full  = (mq.size() == OUTS);
    empty = (mq.size() == 0);
    if (m_stall >= 0)  win = m_stall;
    else if (lv && mv) win = (m_last == 0) ? 1 : 0;
    else               win = mv ? 1 : 0;
    wv   = (win == 1) ? mv : lv;
    edv  = wv && !full;
    head = empty ? -1 : mq[0];
    edrr = !empty && ((head == 1) ? meas_icb_rsp_ready : lsu_icb_rsp_ready);

    chk("dtcm_cmd_valid", 64'(dtcm_icb_cmd_valid), 64'(edv));
    chk("lsu_cmd_ready", 64'(lsu_icb_cmd_ready), 64'(win == 0 && dtcm_icb_cmd_ready && !full));
    chk("meas_cmd_ready", 64'(meas_icb_cmd_ready), 64'(win == 1 && dtcm_icb_cmd_ready && !full));
    if (wv) begin
      chk("cmd_addr", 64'(dtcm_icb_cmd_addr),
          (win == 1) ? 64'(meas_icb_cmd_addr) : 64'(lsu_icb_cmd_addr));
      chk("cmd_read", 64'(dtcm_icb_cmd_read),
          (win == 1) ? 64'(meas_icb_cmd_read) : 64'(lsu_icb_cmd_read));
      chk("cmd_wdata", 64'(dtcm_icb_cmd_wdata),
          (win == 1) ? 64'(meas_icb_cmd_wdata) : 64'(lsu_icb_cmd_wdata));
      chk("cmd_wmask", 64'(dtcm_icb_cmd_wmask),
          (win == 1) ? 64'(meas_icb_cmd_wmask) : 64'(lsu_icb_cmd_wmask));
    end
    chk("lsu_rsp_valid", 64'(lsu_icb_rsp_valid), 64'(dtcm_icb_rsp_valid && head == 0));
    chk("meas_rsp_valid", 64'(meas_icb_rsp_valid), 64'(dtcm_icb_rsp_valid && head == 1));
    chk("dtcm_rsp_ready", 64'(dtcm_icb_rsp_ready), 64'(edrr));
    chk("lsu_rsp_rdata", 64'(lsu_icb_rsp_rdata), 64'(dtcm_icb_rsp_rdata));
    chk("meas_rsp_rdata", 64'(meas_icb_rsp_rdata), 64'(dtcm_icb_rsp_rdata));
    chk("arb_active", 64'(arb_active), 64'(lv || mv || !empty));

    m_win    = win;
    m_acc    = edv && dtcm_icb_cmd_ready;
    m_pop    = dtcm_icb_rsp_valid && edrr;
    m_nstall = (edv && !dtcm_icb_cmd_ready) ? win : (m_acc ? -1 : m_stall);

    l_hsk_q  = lsu_icb_cmd_valid && lsu_icb_cmd_ready;
    m_hsk_q  = meas_icb_cmd_valid && meas_icb_cmd_ready;
    c_hsk_q  = dtcm_icb_cmd_valid && dtcm_icb_cmd_ready;
    r_hsk_q  = dtcm_icb_rsp_valid && dtcm_icb_rsp_ready;
    c_addr_q = dtcm_icb_cmd_addr;
    if (rst_n) begin
      if (c_hsk_q) gnt_log.push_back(meas_icb_cmd_ready ? 1 : 0);
      if (lsu_icb_rsp_valid && lsu_icb_rsp_ready) begin
        rsp_port.push_back(0); rsp_data.push_back(lsu_icb_rsp_rdata);
      end
      if (meas_icb_rsp_valid && meas_icb_rsp_ready) begin
        rsp_port.push_back(1); rsp_data.push_back(meas_icb_rsp_rdata);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_last  = 1;
      m_stall = -1;
    end else begin
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        mq.push_back(m_win);
        m_last = m_win;
      end
      m_stall = m_nstall;
    end
  end

  task automatic drive();
    lsu_icb_cmd_valid  = (lcnt > 0);
    lsu_icb_cmd_addr   = laddr;
    lsu_icb_cmd_read   = 1'b1;
    lsu_icb_cmd_wdata  = {16'h5A00, laddr};
    lsu_icb_cmd_wmask  = 4'hF;
    meas_icb_cmd_valid = (mcnt > 0);
    meas_icb_cmd_addr  = maddr;
    meas_icb_cmd_read  = 1'b0;
    meas_icb_cmd_wdata = {16'hC300, maddr};
    meas_icb_cmd_wmask = 4'h3;
    dtcm_icb_cmd_ready = cmd_rdy;
    dtcm_icb_rsp_valid = rsp_en && (pend.size() > 0);
    dtcm_icb_rsp_rdata = (pend.size() > 0) ? (32'hD000_0000 | 32'(pend[0])) : 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst_n) begin
      pend.delete();
      lcnt = 0;
      mcnt = 0;
    end else begin
      if (r_hsk_q) void'(pend.pop_front());
      if (c_hsk_q) pend.push_back(c_addr_q);
      if (l_hsk_q) begin lcnt--; laddr = laddr + 16'd4; end
      if (m_hsk_q) begin mcnt--; maddr = maddr + 16'd4; end
    end
    drive();
  endtask

  task automatic wait_idle(input string nm);
    bit done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (lcnt == 0 && mcnt == 0 && pend.size() == 0) done = 1;
      else step();
    end
    chk(nm, 64'(done), 64'd1);
  endtask

  task automatic chk_gnt(input string nm, input int n, input logic [7:0] seq);
    chk({nm, "_gnt_count"}, 64'(gnt_log.size()), 64'(n));
    for (int i = 0; i < n && i < gnt_log.size(); i++)
      chk({nm, "_gnt"}, 64'(gnt_log[i]), 64'(seq[i]));
    gnt_log.delete();
  endtask

  task automatic chk_rsp(input string nm, input int n, input logic [7:0] ports,
                         input logic [63:0] addrs);
    chk({nm, "_rsp_count"}, 64'(rsp_port.size()), 64'(n));
    for (int i = 0; i < n && i < rsp_port.size(); i++) begin
      chk({nm, "_rsp_port"}, 64'(rsp_port[i]), 64'(ports[i]));
      chk({nm, "_rsp_data"}, 64'(rsp_data[i]), 64'(32'hD000_0000 | 32'(addrs[8*i +: 8])));
    end
    rsp_port.delete();
    rsp_data.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    lsu_icb_rsp_ready  = 1'b1;
    meas_icb_rsp_ready = 1'b1;
    drive();
    step(); step();
    rst_n = 1'b1;
    #1;
    chk("reset_dtcm_rsp_ready", 64'(dtcm_icb_rsp_ready), 64'd0);
    chk("reset_lsu_rsp_valid", 64'(lsu_icb_rsp_valid), 64'd0);
    chk("reset_arb_active", 64'(arb_active), 64'd0);
    chk("reset_cmd_valid", 64'(dtcm_icb_cmd_valid), 64'd0);

    // S1: LSU-only back-to-back reads.
    lcnt = 3; laddr = 16'h10; drive();
    n = 0;
    while (lcnt > 0 && n < 20) begin step(); n++; end
    chk("s1_cycles", 64'(n), 64'd3);
    wait_idle("s1_drain");
    chk_gnt("s1", 3, 8'h00);
    chk_rsp("s1", 3, 8'h00, 64'h18_14_10);

    // S2: contention, strict alternation starting opposite the last winner (LSU).
    lcnt = 2; laddr = 16'h20; mcnt = 3; maddr = 16'h40; drive();
    n = 0;
    while ((lcnt > 0 || mcnt > 0) && n < 20) begin step(); n++; end
    chk("s2_cycles", 64'(n), 64'd5);
    wait_idle("s2_drain");
    chk_gnt("s2", 5, 8'h15);
    chk_rsp("s2", 5, 8'h15, 64'h48_24_44_20_40);

    // S3: meas stalled; LSU arrives mid-stall, grant stays locked on meas.
    cmd_rdy = 1'b0; mcnt = 1; maddr = 16'h60; drive();
    step(); step();
    lcnt = 1; laddr = 16'h30; drive();
    #1;
    chk("s3_locked_addr", 64'(dtcm_icb_cmd_addr), 64'h60);
    chk("s3_locked_lsu_rdy", 64'(lsu_icb_cmd_ready), 64'd0);
    chk("s3_locked_valid", 64'(dtcm_icb_cmd_valid), 64'd1);
    step();
    cmd_rdy = 1'b1; drive();
    #1;
    chk("s3_meas_rdy", 64'(meas_icb_cmd_ready), 64'd1);
    step();
    #1;
    chk("s3_lsu_next", 64'(lsu_icb_cmd_ready), 64'd1);
    wait_idle("s3_drain");
    chk_gnt("s3", 2, 8'h01);
    chk_rsp("s3", 2, 8'h01, 64'h30_60);

    // S4: fill route FIFO, pop does not free a slot in the same cycle.
    rsp_en = 1'b0; lcnt = 3; laddr = 16'h80; drive();
    step(); step();
    #1;
    chk("s4_full_rdy", 64'(lsu_icb_cmd_ready), 64'd0);
    chk("s4_full_valid", 64'(dtcm_icb_cmd_valid), 64'd0);
    step();
    chk("s4_blocked", 64'(lcnt), 64'd1);
    rsp_en = 1'b1; drive();
    #1;
    chk("s4_pop_ack", 64'(dtcm_icb_rsp_ready), 64'd1);
    chk("s4_pop_same_cycle", 64'(lsu_icb_cmd_ready), 64'd0);
    step();
    #1;
    chk("s4_after_pop", 64'(lsu_icb_cmd_ready), 64'd1);
    wait_idle("s4_drain");
    chk_gnt("s4", 3, 8'h00);
    chk_rsp("s4", 3, 8'h00, 64'h88_84_80);

    // S5: head port back-pressures its response.
    rsp_en = 1'b0; lcnt = 1; laddr = 16'hA0; drive();
    step();
    mcnt = 1; maddr = 16'hC0; drive();
    step();
    lsu_icb_rsp_ready = 1'b0; rsp_en = 1'b1; drive();
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("s5_dtcm_rsp_ready", 64'(dtcm_icb_rsp_ready), 64'd0);
      chk("s5_lsu_rsp_valid", 64'(lsu_icb_rsp_valid), 64'd1);
      chk("s5_meas_rsp_valid", 64'(meas_icb_rsp_valid), 64'd0);
      step();
    end
    lsu_icb_rsp_ready = 1'b1; drive();
    wait_idle("s5_drain");
    chk_gnt("s5", 2, 8'h02);
    chk_rsp("s5", 2, 8'h02, 64'hC0_A0);

    // S6: reset with two outstanding; last winner was LSU, yet next tie goes to LSU.
    rsp_en = 1'b0; mcnt = 1; maddr = 16'hE0; drive();
    step();
    lcnt = 1; laddr = 16'hE4; drive();
    step();
    rst_n = 1'b0;
    pend.delete(); lcnt = 0; mcnt = 0; drive();
    #1;
    chk("s6_rst_lsu_rsp", 64'(lsu_icb_rsp_valid), 64'd0);
    chk("s6_rst_meas_rsp", 64'(meas_icb_rsp_valid), 64'd0);
    chk("s6_rst_active", 64'(arb_active), 64'd0);
    chk("s6_rst_rsp_ready", 64'(dtcm_icb_rsp_ready), 64'd0);
    step(); step();
    rst_n = 1'b1;
    gnt_log.delete(); rsp_port.delete(); rsp_data.delete();
    rsp_en = 1'b1; lcnt = 1; laddr = 16'hF0; mcnt = 1; maddr = 16'hF4; drive();
    #1;
    chk("s6_tie_lsu", 64'(lsu_icb_cmd_ready), 64'd1);
    chk("s6_tie_meas", 64'(meas_icb_cmd_ready), 64'd0);
    wait_idle("s6_drain");
    chk_gnt("s6", 2, 8'h02);
    chk_rsp("s6", 2, 8'h02, 64'hF4_F0);

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
